// File: rtl/piezo_pkg.sv
// Shared types and per-alert tone/cadence tables for the piezo alert sequencer.
package piezo_pkg;

  typedef enum logic [1:0] {IDLE, TONE_ON, TONE_OFF} state_t;

  localparam int TICK_CYC_NORM = 1 << 20;
  localparam int TICK_CYC_FAST = 256;
  localparam int FAST_SHIFT    = 8;

  // Indexed by alert number; entries past the defined alerts stay zero.
  localparam int HALF_PER  [8] = '{4096, 16384, 32768, 0, 0, 0, 0, 0};
  localparam int ON_TICKS  [8] = '{2, 3, 4, 0, 0, 0, 0, 0};
  localparam int OFF_TICKS [8] = '{2, 5, 4, 0, 0, 0, 0, 0};

  function automatic int max_half();
    int m = 1;
    for (int i = 0; i < 8; i++) if (HALF_PER[i] > m) m = HALF_PER[i];
    return m;
  endfunction

  function automatic int max_cadence();
    int m = 1;
    for (int i = 0; i < 8; i++) begin
      if (ON_TICKS[i]  > m) m = ON_TICKS[i];
      if (OFF_TICKS[i] > m) m = OFF_TICKS[i];
    end
    return m;
  endfunction

  localparam int HP_W = $clog2(max_half());

endpackage

// File: rtl/piezo_tone_div.sv
// Half-period counter with a complementary, registered toggle pair.
module piezo_tone_div
  import piezo_pkg::*;
#(
  parameter int W = HP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] hp_last,
  output logic         piezo,
  output logic         piezo_n
);

  logic [W-1:0] cnt;

  // clr starts a fresh phase with piezo high; !en parks both drives low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      piezo   <= 1'b0;
      piezo_n <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      piezo   <= 1'b1;
      piezo_n <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      piezo   <= 1'b0;
      piezo_n <= 1'b0;
    end else if (cnt == hp_last) begin
      cnt     <= '0;
      piezo   <= ~piezo;
      piezo_n <= ~piezo_n;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piezo_alert_seq.sv
// Prioritised piezo alert sequencer: arbitration, ON/OFF cadence and steer-enable timer.
module piezo_alert_seq
  import piezo_pkg::*;
#(
  parameter int NUM_ALERTS     = 3,
  parameter bit fast_sim       = 1'b0,
  parameter int TMR_FULL_TICKS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_ALERTS-1:0] alert_req,
  input  logic                  steer_en_clr_tmr,
  output logic                  piezo,
  output logic                  piezo_n,
  output logic [2:0]            active_alert,
  output logic                  active_vld,
  output logic                  steer_en_tmr_full
);

  localparam int TICK_CYC = fast_sim ? TICK_CYC_FAST : TICK_CYC_NORM;
  localparam int TK_W     = $clog2(TICK_CYC_NORM);
  localparam int PH_W     = $clog2(max_cadence() * TICK_CYC_NORM);
  localparam int TM_W     = $clog2(TMR_FULL_TICKS + 1);

  state_t           state, state_d;
  logic [2:0]       act, act_d, lowest;
  logic [7:0]       req8;
  logic             any_req, start, ph_clr, tick;
  logic [PH_W-1:0]  phase, on_last, off_last;
  logic [HP_W-1:0]  hp_last;
  logic [TK_W-1:0]  pre;
  logic [TM_W-1:0]  tmr;

  always_comb begin
    req8 = '0;
    req8[NUM_ALERTS-1:0] = alert_req;
  end

  assign any_req = |alert_req;

  always_comb begin
    lowest = '0;
    for (int i = 7; i >= 0; i--) if (req8[i]) lowest = 3'(i);
  end

  assign on_last  = PH_W'(ON_TICKS[act]  * TICK_CYC - 1);
  assign off_last = PH_W'(OFF_TICKS[act] * TICK_CYC - 1);
  assign hp_last  = HP_W'((fast_sim ? (HALF_PER[act] >> FAST_SHIFT) : HALF_PER[act]) - 1);

  // While sounding, any change of the winning index (preemption or the
  // active request dropping) restarts the tone with the new winner.
  always_comb begin
    state_d = state;
    act_d   = act;
    start   = 1'b0;
    ph_clr  = 1'b0;
    if (state == IDLE) begin
      if (any_req) begin
        state_d = TONE_ON;
        act_d   = lowest;
        start   = 1'b1;
      end
    end else if (!any_req) begin
      state_d = IDLE;
      act_d   = '0;
    end else if (lowest != act) begin
      state_d = TONE_ON;
      act_d   = lowest;
      start   = 1'b1;
    end else if (state == TONE_ON && phase == on_last) begin
      state_d = TONE_OFF;
      ph_clr  = 1'b1;
    end else if (state == TONE_OFF && phase == off_last) begin
      state_d = TONE_ON;
      start   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      act   <= '0;
      phase <= '0;
    end else begin
      state <= state_d;
      act   <= act_d;
      phase <= (start || ph_clr || state_d == IDLE) ? '0 : phase + 1'b1;
    end
  end

  assign tick = (pre == TK_W'(TICK_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         tmr <= '0;
    else if (steer_en_clr_tmr && !any_req)              tmr <= '0;
    else if (tick && tmr != TM_W'(TMR_FULL_TICKS))      tmr <= tmr + 1'b1;
  end

  assign steer_en_tmr_full = (tmr == TM_W'(TMR_FULL_TICKS));
  assign active_alert      = act;
  assign active_vld        = (state != IDLE);

  piezo_tone_div #(.W(HP_W)) u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start),
    .en      (state_d == TONE_ON),
    .hp_last (hp_last),
    .piezo   (piezo),
    .piezo_n (piezo_n)
  );

endmodule

// File: tb/tb_piezo_alert_seq.sv
// Directed bench for piezo_alert_seq in fast_sim mode: priority table plus cadence/timer/reset sequences.
module tb_piezo_alert_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] alert_req;
  logic       steer_en_clr_tmr;
  logic       piezo, piezo_n, active_vld, steer_en_tmr_full;
  logic [2:0] active_alert;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piezo_alert_seq #(.NUM_ALERTS(3), .fast_sim(1'b1), .TMR_FULL_TICKS(64)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .alert_req         (alert_req),
    .steer_en_clr_tmr  (steer_en_clr_tmr),
    .piezo             (piezo),
    .piezo_n           (piezo_n),
    .active_alert      (active_alert),
    .active_vld        (active_vld),
    .steer_en_tmr_full (steer_en_tmr_full)
  );

  typedef struct {
    logic [2:0] req;
    logic [2:0] act;
    logic       vld;
    logic       p;
    logic       pn;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic p, input logic pn, input logic vld,
                         input logic [2:0] act);
    chk({name, ".piezo"},   32'(piezo),        32'(p));
    chk({name, ".piezo_n"}, 32'(piezo_n),      32'(pn));
    chk({name, ".vld"},     32'(active_vld),   32'(vld));
    chk({name, ".act"},     32'(active_alert), 32'(act));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{req: 3'b111, act: 3'd0, vld: 1'b1, p: 1'b1, pn: 1'b0};
    tbl[1] = '{req: 3'b110, act: 3'd1, vld: 1'b1, p: 1'b1, pn: 1'b0};
    tbl[2] = '{req: 3'b100, act: 3'd2, vld: 1'b1, p: 1'b1, pn: 1'b0};
    tbl[3] = '{req: 3'b110, act: 3'd1, vld: 1'b1, p: 1'b1, pn: 1'b0};
    tbl[4] = '{req: 3'b010, act: 3'd1, vld: 1'b1, p: 1'b1, pn: 1'b0};
    tbl[5] = '{req: 3'b000, act: 3'd0, vld: 1'b0, p: 1'b0, pn: 1'b0};
    tbl[6] = '{req: 3'b011, act: 3'd0, vld: 1'b1, p: 1'b1, pn: 1'b0};
    tbl[7] = '{req: 3'b010, act: 3'd1, vld: 1'b1, p: 1'b1, pn: 1'b0};
    tbl[8] = '{req: 3'b000, act: 3'd0, vld: 1'b0, p: 1'b0, pn: 1'b0};

    rst_n = 1'b0;
    alert_req = 3'b000;
    steer_en_clr_tmr = 1'b0;
    step(3);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 3'd0);
    chk("reset.full", 32'(steer_en_tmr_full), 32'd0);

    // Alert 2 cadence: half-period 128, ON/OFF 1024/1024 clocks
    rst_n = 1'b1;
    alert_req = 3'b100;
    step(1);    chk_out("a2.start", 1'b1, 1'b0, 1'b1, 3'd2);
    step(127);  chk_out("a2.e128",  1'b1, 1'b0, 1'b1, 3'd2);
    step(1);    chk_out("a2.e129",  1'b0, 1'b1, 1'b1, 3'd2);
    step(128);  chk_out("a2.e257",  1'b1, 1'b0, 1'b1, 3'd2);
    step(767);  chk_out("a2.e1024", 1'b0, 1'b1, 1'b1, 3'd2);
    step(1);    chk_out("a2.off",   1'b0, 1'b0, 1'b1, 3'd2);
    step(1023); chk_out("a2.e2048", 1'b0, 1'b0, 1'b1, 3'd2);
    step(1);    chk_out("a2.reon",  1'b1, 1'b0, 1'b1, 3'd2);

    alert_req = 3'b000;
    step(1);    chk_out("a2.idle",  1'b0, 1'b0, 1'b0, 3'd0);

    // Priority / arbitration table, one edge per vector
    for (int i = 0; i < 9; i++) begin
      alert_req = tbl[i].req;
      step(1);
      chk_out($sformatf("tbl%0d", i), tbl[i].p, tbl[i].pn, tbl[i].vld, tbl[i].act);
    end

    // Preemption of alert 2 by alert 0 mid-ON: half-period 16, cadence 512/512
    alert_req = 3'b100;
    step(1);    chk_out("pre.a2",   1'b1, 1'b0, 1'b1, 3'd2);
    step(300);
    alert_req = 3'b101;
    step(1);    chk_out("pre.a0",   1'b1, 1'b0, 1'b1, 3'd0);
    step(15);   chk_out("pre.e15",  1'b1, 1'b0, 1'b1, 3'd0);
    step(1);    chk_out("pre.e16",  1'b0, 1'b1, 1'b1, 3'd0);
    step(495);  chk_out("pre.e511", 1'b0, 1'b1, 1'b1, 3'd0);
    step(1);    chk_out("pre.off",  1'b0, 1'b0, 1'b1, 3'd0);
    step(511);  chk_out("pre.e1023",1'b0, 1'b0, 1'b1, 3'd0);
    step(1);    chk_out("pre.reon", 1'b1, 1'b0, 1'b1, 3'd0);

    // Drop the only request while alert 1 is in TONE_ON
    alert_req = 3'b000;
    step(1);
    alert_req = 3'b010;
    step(10);   chk_out("drop.on",  1'b1, 1'b0, 1'b1, 3'd1);
    alert_req = 3'b000;
    step(1);    chk_out("drop.idle",1'b0, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset mid-tone, request held through release
    alert_req = 3'b001;
    step(20);   chk_out("rst.pre",  1'b0, 1'b1, 1'b1, 3'd0);
    #2 rst_n = 1'b0;
    #1;         chk_out("rst.async",1'b0, 1'b0, 1'b0, 3'd0);
    chk("rst.full", 32'(steer_en_tmr_full), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);    chk_out("rst.rel",  1'b1, 1'b0, 1'b1, 3'd0);

    // Steer timer: 64 ticks of 256 clocks after reset release
    step(16382); chk("tmr.e16383", 32'(steer_en_tmr_full), 32'd0);
    step(1);     chk("tmr.e16384", 32'(steer_en_tmr_full), 32'd1);
    step(300);   chk("tmr.hold",   32'(steer_en_tmr_full), 32'd1);
    steer_en_clr_tmr = 1'b1;
    step(1);     chk("tmr.clr_req", 32'(steer_en_tmr_full), 32'd1);
    step(5);     chk("tmr.clr_req5",32'(steer_en_tmr_full), 32'd1);
    alert_req = 3'b000;
    step(1);     chk("tmr.clr",    32'(steer_en_tmr_full), 32'd0);
    steer_en_clr_tmr = 1'b0;
    step(5);     chk("tmr.after",  32'(steer_en_tmr_full), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
